// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM pipeline stage.
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD, 2'b11 behaves as word)
//   - MEM stage FSM state enum
//   - byte-enable base patterns, shifted by the address offset
//   - data-memory request bundle and the alignment check
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_req_t;

    // Bytes are always aligned; halves need an even address; words (and the
    // reserved size code) need a 4-byte aligned address.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational load data alignment and extension.
//   rdata     in  32  raw word returned by data memory
//   offset    in  2   byte offset of the access within the word
//   size      in  2   access size (SZ_BYTE / SZ_HALF / word)
//   is_signed in  1   1 = sign-extend, 0 = zero-extend
//   ext_data  out 32  aligned, extended load value
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] ext_data
);

    logic [31:0] field;

    // Move the addressed byte lane down to bit 0.
    assign field = rdata >> {offset, 3'b000};

    always_comb begin
        ext_data = field;
        case (size)
            SZ_BYTE: ext_data = {{24{is_signed & field[7]}}, field[7:0]};
            SZ_HALF: ext_data = {{16{is_signed & field[15]}}, field[15:0]};
            default: ext_data = field;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage pipeline.
// Issues loads/stores on a req/ack data-memory bus, stalls upstream while an
// access is outstanding, and forms the write-back value for MEM/WB.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   PC_in .. Rd_in           EX/MEM register contents (held frozen by stall)
//   PC_out, RegWrite_out,
//   Write_data_out, Rd_out   MEM/WB inputs
//   stall                    freezes PC, IF/ID, ID/EX, EX/MEM
//   misalign_exc             one-cycle pulse after a misaligned access
//   bus_err                  one-cycle pulse on a timeout abort
//   dmem_*                   data-memory request/acknowledge bus
//
// Optional build macro MEM_TIMEOUT_EN: aborts an access after TIMEOUT_CYC
// WAIT cycles without ack. Without it the stage waits forever and bus_err is 0.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_in,
    input  logic        RegWrite_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [1:0]  MemSize_in,
    input  logic        MemSigned_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] Store_data_in,
    input  logic [4:0]  Rd_in,
    output logic [31:0] PC_out,
    output logic        RegWrite_out,
    output logic [31:0] Write_data_out,
    output logic [4:0]  Rd_out,
    output logic        stall,
    output logic        misalign_exc,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    state_t      state, state_nxt;
    bus_req_t    req_nxt, req_q;
    logic        req_vld;
    logic [31:0] rdata_q;
    logic [31:0] ld_data;
    logic [1:0]  off;
    logic        mem_op, misaligned, start, timeout, aborted;

    assign off        = ALU_result_in[1:0];
    assign mem_op     = MemRead_in | MemWrite_in;
    assign misaligned = mem_op & is_misaligned(MemSize_in, off);
    assign start      = (state == ST_IDLE) && mem_op && !misaligned;

    // Store data is replicated across lanes so the byte enables alone pick
    // the bytes memory actually writes.
    always_comb begin
        req_nxt.we   = MemWrite_in;
        req_nxt.addr = {ALU_result_in[31:2], 2'b00};
        case (MemSize_in)
            SZ_BYTE: begin
                req_nxt.wdata = {4{Store_data_in[7:0]}};
                req_nxt.be    = BE_BYTE << off;
            end
            SZ_HALF: begin
                req_nxt.wdata = {2{Store_data_in[15:0]}};
                req_nxt.be    = BE_HALF << off;
            end
            default: begin
                req_nxt.wdata = Store_data_in;
                req_nxt.be    = BE_WORD;
            end
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       bus_err_q, aborted_q;

    assign timeout = (state == ST_WAIT) && !dmem_ack && (wait_cnt == 8'(TIMEOUT_CYC - 1));
    assign bus_err = bus_err_q;
    assign aborted = aborted_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            bus_err_q <= timeout;
            wait_cnt  <= (state == ST_WAIT) ? wait_cnt + 8'd1 : 8'd0;
            // Remembered through DONE so the aborted load never writes back.
            if (start)
                aborted_q <= 1'b0;
            else if (timeout)
                aborted_q <= 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign aborted    = 1'b0;
    assign bus_err    = 1'b0;
    // The timeout limit only has meaning when the counter is built.
    assign unused_cfg = (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        stall          = 1'b0;
        RegWrite_out   = RegWrite_in;
        Write_data_out = ALU_result_in;
        case (state)
            ST_IDLE: begin
                if (mem_op) begin
                    RegWrite_out = 1'b0;
                    if (!misaligned) begin
                        stall     = 1'b1;
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                stall        = 1'b1;
                RegWrite_out = 1'b0;
                if (dmem_ack || timeout)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                // EX/MEM still holds the memory instruction this cycle.
                state_nxt = ST_IDLE;
                if (MemRead_in)
                    Write_data_out = ld_data;
                if (MemWrite_in || aborted)
                    RegWrite_out = 1'b0;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (rst) begin
            stall        = 1'b0;
            RegWrite_out = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q        <= '0;
            req_vld      <= 1'b0;
            rdata_q      <= '0;
            misalign_exc <= 1'b0;
        end else begin
            misalign_exc <= (state == ST_IDLE) && misaligned;
            if (start) begin
                req_q   <= req_nxt;
                req_vld <= 1'b1;
            end else if ((state == ST_WAIT) && (dmem_ack || timeout)) begin
                req_vld <= 1'b0;
            end
            if ((state == ST_WAIT) && dmem_ack)
                rdata_q <= dmem_rdata;
        end
    end

    load_align u_load_align (
        .rdata     (rdata_q),
        .offset    (off),
        .size      (MemSize_in),
        .is_signed (MemSigned_in),
        .ext_data  (ld_data)
    );

    assign PC_out     = PC_in;
    assign Rd_out     = Rd_in;
    assign dmem_req   = req_vld;
    assign dmem_we    = req_q.we;
    assign dmem_addr  = req_q.addr;
    assign dmem_wdata = req_q.wdata;
    assign dmem_be    = req_q.be;

endmodule
